// File: rtl/down_counter_timer.sv
// Loadable down counter / interval timer with one-shot or periodic reload.
// Terminal count is flagged by a one-cycle registered tc pulse.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] ldvalue,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] dout,
  output logic             tc,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      dout_q   <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      dout_q   <= dout_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dout_d   = dout_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (ld) begin
      reload_d = ldvalue;
      dout_d   = ldvalue;
      state_d  = (ldvalue != ZERO) ? RUN : IDLE;
    end else begin
      unique case (state_q)
        RUN: begin
          if (en) begin
            // dout is never 0 in RUN, so <=1 is the terminal count
            if (dout_q > ONE) begin
              dout_d = dout_q - ONE;
            end else begin
              tc_d = 1'b1;
              if (auto_reload) begin
                dout_d = reload_q;
              end else begin
                dout_d  = ZERO;
                state_d = IDLE;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign dout = dout_q;
  assign tc   = tc_q;
  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer.
// Inputs change #1 after each rising edge; outputs are sampled there too.
module tb_down_counter_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ld = 1'b0;
  logic [3:0] ldvalue = '0;
  logic       en = 1'b0;
  logic       auto_reload = 1'b0;
  logic [3:0] dout;
  logic       tc;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  down_counter_timer #(.WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .ld(ld),
    .ldvalue(ldvalue),
    .en(en),
    .auto_reload(auto_reload),
    .dout(dout),
    .tc(tc),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ld = 1'b1; ldvalue = 4'hA; en = 1'b1;
    tick(); tick();
    rst = 1'b0; ld = 1'b0;
    n_tests++;
    if (dout !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: dout=%0d tc=%b busy=%b, want 0 0 0",
               dout, tc, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (dout !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: dout=%0d tc=%b busy=%b, want 0 0 0",
                 i, dout, tc, busy);
      end
    end
  endtask

  task automatic test_one_shot();
    logic [3:0] exp_d [5] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    logic       exp_t [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       exp_b [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ld = 1'b1; ldvalue = 4'd5; en = 1'b1; auto_reload = 1'b0;
    tick();
    ld = 1'b0;
    n_tests++;
    if (dout !== 4'd5 || tc !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL oneshot_load: dout=%0d tc=%b busy=%b, want 5 0 1",
               dout, tc, busy);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (dout !== exp_d[i] || tc !== exp_t[i] || busy !== exp_b[i]) begin
        n_fail++;
        $display("FAIL oneshot[%0d]: dout=%0d tc=%b busy=%b, want %0d %b %b",
                 i, dout, tc, busy, exp_d[i], exp_t[i], exp_b[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (dout !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL oneshot_hold[%0d]: dout=%0d tc=%b busy=%b, want 0 0 0",
                 i, dout, tc, busy);
      end
    end
  endtask

  task automatic test_auto_reload();
    logic [3:0] exp_d [3] = '{4'd2, 4'd1, 4'd3};
    int pulses = 0;
    ld = 1'b1; ldvalue = 4'd3; en = 1'b1; auto_reload = 1'b1;
    tick();
    ld = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (tc === 1'b1) pulses++;
      n_tests++;
      if (dout !== exp_d[(i-1)%3] || tc !== (i % 3 == 0) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL autoreload[%0d]: dout=%0d tc=%b busy=%b, want %0d %b 1",
                 i, dout, tc, busy, exp_d[(i-1)%3], (i % 3 == 0));
      end
    end
    n_tests++;
    if (pulses != 4) begin
      n_fail++;
      $display("FAIL autoreload_pulses: got %0d, want 4", pulses);
    end
    auto_reload = 1'b0;
  endtask

  task automatic test_enable();
    logic       ens   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] exp_d [6] = '{4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0};
    int pulses = 0;
    ld = 1'b1; ldvalue = 4'd4; en = 1'b0; auto_reload = 1'b0;
    tick();
    ld = 1'b0;
    n_tests++;
    if (dout !== 4'd4 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL enable_load: dout=%0d busy=%b, want 4 1", dout, busy);
    end
    for (int i = 0; i < 6; i++) begin
      en = ens[i];
      tick();
      if (tc === 1'b1) pulses++;
      n_tests++;
      if (dout !== exp_d[i]) begin
        n_fail++;
        $display("FAIL enable[%0d]: dout=%0d, want %0d", i, dout, exp_d[i]);
      end
    end
    n_tests++;
    if (pulses != 1 || tc !== 1'b1) begin
      n_fail++;
      $display("FAIL enable_tc: pulses=%0d last_tc=%b, want 1 1", pulses, tc);
    end
  endtask

  task automatic test_collision();
    ld = 1'b1; ldvalue = 4'd2; en = 1'b1; auto_reload = 1'b0;
    tick();
    ld = 1'b0;
    tick();
    ld = 1'b1; ldvalue = 4'd7;
    tick();
    ld = 1'b0;
    n_tests++;
    if (dout !== 4'd7 || tc !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ld_at_tc: dout=%0d tc=%b busy=%b, want 7 0 1",
               dout, tc, busy);
    end
    tick();
    n_tests++;
    if (dout !== 4'd6) begin
      n_fail++;
      $display("FAIL ld_at_tc_next: dout=%0d, want 6", dout);
    end
    ld = 1'b1; ldvalue = 4'd0;
    tick();
    ld = 1'b0;
    n_tests++;
    if (dout !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ld_zero: dout=%0d tc=%b busy=%b, want 0 0 0",
               dout, tc, busy);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_tests++;
      if (tc !== 1'b0 || dout !== 4'd0) begin
        n_fail++;
        $display("FAIL ld_zero_after[%0d]: dout=%0d tc=%b, want 0 0",
                 i, dout, tc);
      end
    end
  endtask

  task automatic test_max_period();
    int cycles = 0;
    ld = 1'b1; ldvalue = 4'hF; en = 1'b1; auto_reload = 1'b0;
    tick();
    ld = 1'b0;
    n_tests++;
    if (dout !== 4'hF) begin
      n_fail++;
      $display("FAIL max_load: dout=%0d, want 15", dout);
    end
    while (cycles < 20) begin
      tick();
      cycles++;
      if (tc === 1'b1) break;
    end
    n_tests++;
    if (cycles != 15 || tc !== 1'b1 || dout !== 4'd0) begin
      n_fail++;
      $display("FAIL max_period: cycles=%0d tc=%b dout=%0d, want 15 1 0",
               cycles, tc, dout);
    end
  endtask

  task automatic test_reset_mid_run();
    ld = 1'b1; ldvalue = 4'd9; en = 1'b1; auto_reload = 1'b1;
    tick();
    ld = 1'b0;
    tick(); tick(); tick();
    n_tests++;
    if (dout !== 4'd6) begin
      n_fail++;
      $display("FAIL midrun_count: dout=%0d, want 6", dout);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (dout !== 4'd0 || busy !== 1'b0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_rst: dout=%0d busy=%b tc=%b, want 0 0 0",
               dout, busy, tc);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      n_tests++;
      if (tc !== 1'b0 || dout !== 4'd0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midrun_after[%0d]: dout=%0d busy=%b tc=%b, want 0 0 0",
                 i, dout, busy, tc);
      end
    end
    ld = 1'b1; ldvalue = 4'd1;
    tick();
    ld = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (tc !== 1'b0 || dout !== 4'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_at_tc: dout=%0d busy=%b tc=%b, want 0 0 0",
               dout, busy, tc);
    end
    auto_reload = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_enable();
    test_collision();
    test_max_period();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
